// File: rtl/board_ctrl_if.sv
// Move-request and board-status bundle between the input stage and board_ctrl.
// master drives the move request, slave (board_ctrl) drives the board status.
interface board_ctrl_if;
    logic [3:0]  update_loc;
    logic [1:0]  update_val;
    logic        submit;
    logic [17:0] board;
    logic [1:0]  turn;
    logic        accept;
    logic        reject;
    logic        busy;
    logic        game_over;
    logic [1:0]  winner;

    modport master (
        output update_loc, update_val, submit,
        input  board, turn, accept, reject, busy, game_over, winner
    );

    modport slave (
        input  update_loc, update_val, submit,
        output board, turn, accept, reject, busy, game_over, winner
    );
endinterface

// File: rtl/board_ctrl.sv
// Tic-tac-toe board controller: validates moves, writes the board, detects win/draw.
// Latency: accept/reject 2 clocks after the submit edge, turn/game_over/winner 3 clocks.
// Backpressure: submit edges arriving while busy are dropped, never queued.
// Optional TTT_TURN_ENFORCE_EN: also refuses a mark that is not the expected turn.
module board_ctrl (
    input  logic         clk,
    input  logic         reset,
    board_ctrl_if.slave  bus
);
    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    typedef enum logic [1:0] {IDLE, CHECK, WRITE, EVAL} state_t;

    state_t      state;
    logic        sub_q;
    logic [3:0]  loc_q;
    logic [1:0]  val_q;
    logic [17:0] board_q;
    logic [1:0]  turn_q;
    logic        accept_q;
    logic        reject_q;
    logic        busy_q;
    logic        game_over_q;
    logic [1:0]  winner_q;

    logic        sub_edge;
    logic [1:0]  target;
    logic        illegal;
    logic [1:0]  win;
    logic        full;

    function automatic logic [1:0] line3(input logic [17:0] b, input int a, input int c, input int d);
        logic [1:0] m;
        m = b[2*a +: 2];
        return ((m != CELL_EMPTY) && (b[2*c +: 2] == m) && (b[2*d +: 2] == m)) ? m : CELL_EMPTY;
    endfunction

    assign sub_edge = bus.submit & ~sub_q;

    always_comb begin
        target = CELL_EMPTY;
        for (int i = 0; i < 9; i++) begin
            if (loc_q == 4'(i)) target = board_q[2*i +: 2];
        end
        illegal = (loc_q > 4'd8) || (val_q == CELL_EMPTY) || (val_q == 2'b11) ||
                  (target != CELL_EMPTY);
`ifdef TTT_TURN_ENFORCE_EN
        if (val_q != turn_q) illegal = 1'b1;
`endif
    end

    // Evaluated on the registered board, which already holds the new mark in WRITE.
    always_comb begin
        win = CELL_EMPTY;
        if (win == CELL_EMPTY) win = line3(board_q, 0, 1, 2);
        if (win == CELL_EMPTY) win = line3(board_q, 3, 4, 5);
        if (win == CELL_EMPTY) win = line3(board_q, 6, 7, 8);
        if (win == CELL_EMPTY) win = line3(board_q, 0, 3, 6);
        if (win == CELL_EMPTY) win = line3(board_q, 1, 4, 7);
        if (win == CELL_EMPTY) win = line3(board_q, 2, 5, 8);
        if (win == CELL_EMPTY) win = line3(board_q, 0, 4, 8);
        if (win == CELL_EMPTY) win = line3(board_q, 2, 4, 6);
        full = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (board_q[2*i +: 2] == CELL_EMPTY) full = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sub_q       <= 1'b1;
            loc_q       <= '0;
            val_q       <= CELL_EMPTY;
            board_q     <= '0;
            turn_q      <= CELL_X;
            accept_q    <= 1'b0;
            reject_q    <= 1'b0;
            busy_q      <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= CELL_EMPTY;
        end else begin
            sub_q    <= bus.submit;
            accept_q <= 1'b0;
            reject_q <= 1'b0;
            case (state)
                IDLE: begin
                    // busy_q still high here only for the reject-pulse cycle.
                    busy_q <= 1'b0;
                    if (sub_edge && !busy_q) begin
                        if (game_over_q) begin
                            reject_q <= 1'b1;
                        end else begin
                            loc_q  <= bus.update_loc;
                            val_q  <= bus.update_val;
                            busy_q <= 1'b1;
                            state  <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (illegal) begin
                        reject_q <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        board_q  <= board_q | ({16'b0, val_q} << {loc_q, 1'b0});
                        accept_q <= 1'b1;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (win != CELL_EMPTY) begin
                        winner_q    <= win;
                        game_over_q <= 1'b1;
                    end else if (full) begin
                        winner_q    <= CELL_EMPTY;
                        game_over_q <= 1'b1;
                    end else begin
                        turn_q <= (val_q == CELL_X) ? CELL_O : CELL_X;
                    end
                    state <= EVAL;
                end
                EVAL: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.board     = board_q;
    assign bus.turn      = turn_q;
    assign bus.accept    = accept_q;
    assign bus.reject    = reject_q;
    assign bus.busy      = busy_q;
    assign bus.game_over = game_over_q;
    assign bus.winner    = winner_q;
endmodule

// File: tb/tb_board_ctrl.sv
// Directed bench for board_ctrl: timing, legality checks, win/draw and reset/busy behaviour.
module tb_board_ctrl;
    localparam logic [1:0] E = 2'b00;
    localparam logic [1:0] X = 2'b01;
    localparam logic [1:0] O = 2'b10;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   acc;
    int   rej;
    int   acc_tot;
    int   a2;
    int   r2;

    board_ctrl_if bus();

    board_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic window(input int n, output int a, output int r);
        a = 0;
        r = 0;
        repeat (n) begin
            tick();
            a += int'(bus.accept);
            r += int'(bus.reject);
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus.submit     = 1'b0;
        bus.update_loc = 4'd0;
        bus.update_val = E;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    // One submit pulse then enough idle cycles for the full accept path.
    task automatic move(input logic [3:0] l, input logic [1:0] v, output int a, output int r);
        int ta, tr, tb2, tr2;
        bus.update_loc = l;
        bus.update_val = v;
        bus.submit     = 1'b1;
        window(2, ta, tr);
        bus.submit = 1'b0;
        window(3, tb2, tr2);
        a = ta + tb2;
        r = tr + tr2;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.submit = 1'b0;
        bus.update_loc = 4'd0;
        bus.update_val = E;

        // Reset state
        do_reset();
        check("rst_board", 32'(bus.board), 32'h0);
        check("rst_turn", 32'(bus.turn), 32'(X));
        check("rst_pulses", {30'b0, bus.accept, bus.reject}, 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_game_over", 32'(bus.game_over), 32'h0);
        check("rst_winner", 32'(bus.winner), 32'(E));

        // Cycle-accurate legal X@0
        bus.update_loc = 4'd0;
        bus.update_val = X;
        bus.submit     = 1'b1;
        tick();
        check("t_n_busy", 32'(bus.busy), 32'h1);
        check("t_n_accept", 32'(bus.accept), 32'h0);
        tick();
        check("t_n1_accept", 32'(bus.accept), 32'h1);
        check("t_n1_board", 32'(bus.board), 32'h1);
        check("t_n1_turn", 32'(bus.turn), 32'(X));
        tick();
        check("t_n2_accept", 32'(bus.accept), 32'h0);
        check("t_n2_turn", 32'(bus.turn), 32'(O));
        check("t_n2_busy", 32'(bus.busy), 32'h1);
        tick();
        check("t_n3_busy", 32'(bus.busy), 32'h0);
        bus.submit = 1'b0;
        tick();

        // X@8 held 5 cycles is a single request
        bus.update_loc = 4'd8;
        bus.update_val = X;
        bus.submit     = 1'b1;
        window(5, acc, rej);
        bus.submit = 1'b0;
        window(3, a2, r2);
        acc += a2;
        rej += r2;
`ifdef TTT_TURN_ENFORCE_EN
        check("hold_rejects", 32'(rej), 32'd1);
        check("hold_accepts", 32'(acc), 32'd0);
        check("hold_cell8", 32'(bus.board[17:16]), 32'(E));
        check("hold_turn", 32'(bus.turn), 32'(O));
`else
        check("hold_rejects", 32'(rej), 32'd0);
        check("hold_accepts", 32'(acc), 32'd1);
        check("hold_cell8", 32'(bus.board[17:16]), 32'(X));
        check("hold_turn", 32'(bus.turn), 32'(O));
`endif

        // Wrong first mover
        do_reset();
        move(4'd0, O, acc, rej);
`ifdef TTT_TURN_ENFORCE_EN
        check("first_o_rej", 32'(rej), 32'd1);
        check("first_o_board", 32'(bus.board), 32'h0);
`else
        check("first_o_acc", 32'(acc), 32'd1);
        check("first_o_board", 32'(bus.board), 32'h2);
`endif
        check("first_o_turn", 32'(bus.turn), 32'(X));

        // Occupied, range and illegal codes
        do_reset();
        move(4'd0, X, acc, rej);
        move(4'd4, O, a2, r2);
        check("occ_setup_acc", 32'(acc + a2), 32'd2);
        move(4'd4, X, acc, rej);
        check("occ_rej", 32'(rej), 32'd1);
        move(4'd9, X, acc, rej);
        check("range_rej", 32'(rej), 32'd1);
        move(4'd1, 2'b11, acc, rej);
        check("code11_rej", 32'(rej), 32'd1);
        move(4'd2, E, acc, rej);
        check("empty_rej", 32'(rej), 32'd1);
        check("occ_board", 32'(bus.board), 32'h201);
        check("occ_turn", 32'(bus.turn), 32'(X));

        // Win on top row
        do_reset();
        acc_tot = 0;
        move(4'd0, X, acc, rej); acc_tot += acc;
        move(4'd3, O, acc, rej); acc_tot += acc;
        move(4'd1, X, acc, rej); acc_tot += acc;
        move(4'd4, O, acc, rej); acc_tot += acc;
        check("win_pre_game_over", 32'(bus.game_over), 32'h0);
        move(4'd2, X, acc, rej); acc_tot += acc;
        check("win_accepts", 32'(acc_tot), 32'd5);
        check("win_game_over", 32'(bus.game_over), 32'h1);
        check("win_winner", 32'(bus.winner), 32'(X));
        check("win_board", 32'(bus.board), 32'h295);
        move(4'd5, O, acc, rej);
        check("post_win_rej", 32'(rej), 32'd1);
        check("post_win_acc", 32'(acc), 32'd0);
        check("post_win_board", 32'(bus.board), 32'h295);

        // Draw
        do_reset();
        acc_tot = 0;
        move(4'd0, X, acc, rej); acc_tot += acc;
        move(4'd1, O, acc, rej); acc_tot += acc;
        move(4'd2, X, acc, rej); acc_tot += acc;
        move(4'd4, O, acc, rej); acc_tot += acc;
        move(4'd3, X, acc, rej); acc_tot += acc;
        move(4'd5, O, acc, rej); acc_tot += acc;
        move(4'd7, X, acc, rej); acc_tot += acc;
        move(4'd6, O, acc, rej); acc_tot += acc;
        check("draw_pre_game_over", 32'(bus.game_over), 32'h0);
        move(4'd8, X, acc, rej); acc_tot += acc;
        check("draw_accepts", 32'(acc_tot), 32'd9);
        check("draw_game_over", 32'(bus.game_over), 32'h1);
        check("draw_winner", 32'(bus.winner), 32'(E));
        check("draw_board", 32'(bus.board), 32'h16A59);

        // Reset during CHECK, then submit held across reset release
        do_reset();
        bus.update_loc = 4'd0;
        bus.update_val = X;
        bus.submit     = 1'b1;
        tick();
        check("midrst_busy", 32'(bus.busy), 32'h1);
        reset = 1'b1;
        tick();
        check("midrst_accept", 32'(bus.accept), 32'h0);
        check("midrst_board", 32'(bus.board), 32'h0);
        reset = 1'b0;
        window(6, acc, rej);
        check("held_release_pulses", 32'(acc + rej), 32'd0);
        check("held_release_busy", 32'(bus.busy), 32'h0);
        check("held_release_board", 32'(bus.board), 32'h0);
        bus.submit = 1'b0;
        tick();

        // Second edge while busy is dropped
        bus.update_loc = 4'd0;
        bus.update_val = X;
        bus.submit     = 1'b1;
        window(1, acc, rej);
        bus.submit = 1'b0;
        window(1, a2, r2);
        acc += a2;
        rej += r2;
        bus.update_loc = 4'd4;
        bus.update_val = O;
        bus.submit     = 1'b1;
        window(3, a2, r2);
        acc += a2;
        rej += r2;
        bus.submit = 1'b0;
        window(4, a2, r2);
        acc += a2;
        rej += r2;
        check("drop_accepts", 32'(acc), 32'd1);
        check("drop_rejects", 32'(rej), 32'd0);
        check("drop_board", 32'(bus.board), 32'h1);
        check("drop_turn", 32'(bus.turn), 32'(O));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
